// File: rtl/hash_table.sv
// Shared hash-table types: command/result payloads, result codes and engine
// numbering used by the task scheduler and the command engines.
package hash_table;

    localparam int unsigned KEY_W      = 16;
    localparam int unsigned VALUE_W    = 16;
    localparam int unsigned BUCKET_W   = 8;
    localparam int unsigned ENG_IDX_W  = 2;

    localparam int unsigned ENG_SEARCH = 0;
    localparam int unsigned ENG_INSERT = 1;
    localparam int unsigned ENG_DELETE = 2;
    localparam int unsigned ENG_INIT   = 3;

    typedef enum logic [2:0] {
        OP_SEARCH = 3'd0,
        OP_INSERT = 3'd1,
        OP_DELETE = 3'd2,
        OP_INIT   = 3'd3
    } ht_cmd_t;

    typedef enum logic [2:0] {
        SUCCESS        = 3'd0,
        KEY_EXISTS     = 3'd1,
        KEY_NOT_EXISTS = 3'd2,
        TABLE_FULL     = 3'd3,
        UNKNOWN_CMD    = 3'd4
    } ht_rescode_t;

    typedef enum logic [1:0] {
        IDLE_S     = 2'd0,
        DISPATCH_S = 2'd1,
        WAIT_RES_S = 2'd2,
        REPORT_S   = 2'd3
    } ht_sched_state_t;

    typedef struct packed {
        ht_cmd_t              cmd;
        logic [KEY_W-1:0]     key;
        logic [VALUE_W-1:0]   value;
    } ht_pdata_t;

    typedef struct packed {
        ht_cmd_t              cmd;
        ht_rescode_t          rescode;
        logic [KEY_W-1:0]     key;
        logic [VALUE_W-1:0]   value;
        logic [BUCKET_W-1:0]  bucket;
    } ht_result_t;

    typedef struct packed {
        logic                 legal;
        logic [ENG_IDX_W-1:0] idx;
    } ht_eng_sel_t;

    // Map a command onto the engine that executes it; legal=0 for unknown commands.
    function automatic ht_eng_sel_t decode_cmd(input ht_cmd_t cmd);
        ht_eng_sel_t sel;
        sel = '0;
        case (cmd)
            OP_SEARCH: begin sel.legal = 1'b1; sel.idx = ENG_IDX_W'(ENG_SEARCH); end
            OP_INSERT: begin sel.legal = 1'b1; sel.idx = ENG_IDX_W'(ENG_INSERT); end
            OP_DELETE: begin sel.legal = 1'b1; sel.idx = ENG_IDX_W'(ENG_DELETE); end
            OP_INIT:   begin sel.legal = 1'b1; sel.idx = ENG_IDX_W'(ENG_INIT);   end
            default:   sel = '0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ht_task_sched.sv
// Single-task scheduler: locks one incoming task, dispatches it to the engine
// selected by its command, collects that engine's result and reports it.
module ht_task_sched
    import hash_table::*;
#(
    parameter int unsigned ENG_NUM   = 4,
    parameter int unsigned WD_CYCLES = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  ht_pdata_t                 task_i,
    input  logic                      task_valid_i,
    output logic                      task_ready_o,
    output ht_pdata_t                 eng_task_o,
    output logic [ENG_NUM-1:0]        eng_task_valid_o,
    input  logic [ENG_NUM-1:0]        eng_task_ready_i,
    input  ht_result_t [ENG_NUM-1:0]  eng_result_i,
    input  logic [ENG_NUM-1:0]        eng_result_valid_i,
    output logic [ENG_NUM-1:0]        eng_result_ready_o,
    output ht_result_t                result_o,
    output logic                      result_valid_o,
    input  logic                      result_ready_i,
    output logic                      busy_o,
    output logic                      wd_err_o
);

    localparam int unsigned ENG_W = (ENG_NUM > 1) ? $clog2(ENG_NUM) : 1;
    localparam int unsigned CNT_W = $clog2(WD_CYCLES) + 1;

    ht_sched_state_t     state_q, state_d;
    ht_pdata_t           task_q, task_d;
    ht_result_t          result_q, result_d;
    logic [ENG_W-1:0]    eng_q, eng_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wd_err_q, wd_err_d;
    logic                task_ready_d, busy_d, result_valid_d;
    logic [ENG_NUM-1:0]  eng_valid_d, eng_rready_d;
    ht_eng_sel_t         sel;

    // State, payload registers and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q            <= IDLE_S;
            task_q             <= '0;
            result_q           <= '0;
            eng_q              <= '0;
            cnt_q              <= '0;
            wd_err_q           <= 1'b0;
            task_ready_o       <= 1'b1;
            busy_o             <= 1'b0;
            result_valid_o     <= 1'b0;
            eng_task_valid_o   <= '0;
            eng_result_ready_o <= '0;
        end else begin
            state_q            <= state_d;
            task_q             <= task_d;
            result_q           <= result_d;
            eng_q              <= eng_d;
            cnt_q              <= cnt_d;
            wd_err_q           <= wd_err_d;
            task_ready_o       <= task_ready_d;
            busy_o             <= busy_d;
            result_valid_o     <= result_valid_d;
            eng_task_valid_o   <= eng_valid_d;
            eng_result_ready_o <= eng_rready_d;
        end
    end

    // Next state, payload capture, watchdog and next output values
    always_comb begin
        state_d  = state_q;
        task_d   = task_q;
        result_d = result_q;
        eng_d    = eng_q;
        cnt_d    = cnt_q;
        wd_err_d = wd_err_q;
        sel      = '0;

        case (state_q)
            IDLE_S: begin
                if (task_valid_i && task_ready_o) begin
                    task_d = task_i;
                    sel    = decode_cmd(task_i.cmd);
                    if (sel.legal) begin
                        eng_d   = ENG_W'(sel.idx);
                        state_d = DISPATCH_S;
                    end else begin
                        result_d         = '0;
                        result_d.cmd     = task_i.cmd;
                        result_d.rescode = UNKNOWN_CMD;
                        state_d          = REPORT_S;
                    end
                end
            end
            DISPATCH_S: begin
                if (eng_task_valid_o[eng_q] && eng_task_ready_i[eng_q]) begin
                    state_d = WAIT_RES_S;
                end
            end
            WAIT_RES_S: begin
                if (eng_result_valid_i[eng_q] && eng_result_ready_o[eng_q]) begin
                    result_d = eng_result_i[eng_q];
                    state_d  = REPORT_S;
                end
            end
            REPORT_S: begin
                if (result_valid_o && result_ready_i) begin
                    state_d = IDLE_S;
                end
            end
            default: state_d = IDLE_S;
        endcase

        // Watchdog only flags a stuck task; it never aborts it
        if (state_q == IDLE_S) begin
            cnt_d = '0;
        end else if ((state_q == DISPATCH_S || state_q == WAIT_RES_S) &&
                     (cnt_q != CNT_W'(WD_CYCLES))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_d == CNT_W'(WD_CYCLES)) begin
            wd_err_d = 1'b1;
        end

        task_ready_d   = (state_d == IDLE_S);
        busy_d         = (state_d != IDLE_S);
        result_valid_d = (state_d == REPORT_S);
        eng_valid_d    = (state_d == DISPATCH_S) ? (ENG_NUM'(1) << eng_d) : '0;
        eng_rready_d   = (state_d == WAIT_RES_S) ? (ENG_NUM'(1) << eng_d) : '0;
    end

    assign eng_task_o = task_q;
    assign result_o   = result_q;
    assign wd_err_o   = wd_err_q;

endmodule

// File: tb/tb_ht_task_sched.sv
// Bench for ht_task_sched: table of tasks with a reactive engine model and a
// result scoreboard, plus a watchdog/reset sequence.
module tb_ht_task_sched;
    import hash_table::*;

    localparam int unsigned ENG_NUM = 4;
    localparam int unsigned WD      = 16;

    logic                     clk = 1'b0;
    logic                     rst_i;
    ht_pdata_t                task_i;
    logic                     task_valid_i;
    logic                     task_ready_o;
    ht_pdata_t                eng_task_o;
    logic [ENG_NUM-1:0]       eng_task_valid_o;
    logic [ENG_NUM-1:0]       eng_task_ready_i;
    ht_result_t [ENG_NUM-1:0] eng_result_i;
    logic [ENG_NUM-1:0]       eng_result_valid_i;
    logic [ENG_NUM-1:0]       eng_result_ready_o;
    ht_result_t               result_o;
    logic                     result_valid_o;
    logic                     result_ready_i;
    logic                     busy_o;
    logic                     wd_err_o;

    always #5 clk = ~clk;

    ht_task_sched #(.ENG_NUM(ENG_NUM), .WD_CYCLES(WD)) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .task_i             (task_i),
        .task_valid_i       (task_valid_i),
        .task_ready_o       (task_ready_o),
        .eng_task_o         (eng_task_o),
        .eng_task_valid_o   (eng_task_valid_o),
        .eng_task_ready_i   (eng_task_ready_i),
        .eng_result_i       (eng_result_i),
        .eng_result_valid_i (eng_result_valid_i),
        .eng_result_ready_o (eng_result_ready_o),
        .result_o           (result_o),
        .result_valid_o     (result_valid_o),
        .result_ready_i     (result_ready_i),
        .busy_o             (busy_o),
        .wd_err_o           (wd_err_o)
    );

    typedef struct {
        ht_cmd_t    cmd;
        logic [15:0] key;
        logic [15:0] value;
        bit         legal;
        int         eng;
        logic [3:0] onehot;
        int         rdy;       // engine ready in this valid cycle (1-based)
        int         res;       // wait-state cycles before engine result
        int         rr;        // cycles result_ready_i is held low
        bit         noise;     // other engines (and early selected) drive bogus results
        int         exp_vcyc;  // cycles eng_task_valid_o is high
        int         exp_lat;   // cycles from accept to result_valid_o
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    ht_result_t sb_q[$];
    vec_t       vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input ht_cmd_t cmd, input logic [15:0] key, input logic [15:0] value,
                                input bit legal, input int eng, input int rdy, input int res,
                                input int rr, input bit noise, input int exp_vcyc, input int exp_lat);
        vec_t v;
        v.cmd = cmd; v.key = key; v.value = value; v.legal = legal; v.eng = eng;
        v.onehot = legal ? (4'b0001 << eng) : 4'b0000;
        v.rdy = rdy; v.res = res; v.rr = rr; v.noise = noise;
        v.exp_vcyc = exp_vcyc; v.exp_lat = exp_lat;
        return v;
    endfunction

    function automatic ht_result_t engine_model(input ht_pdata_t t);
        ht_result_t r;
        r.cmd     = t.cmd;
        r.rescode = (t.cmd == OP_SEARCH) ? KEY_NOT_EXISTS : SUCCESS;
        r.key     = t.key;
        r.value   = t.value ^ 16'h5A5A;
        r.bucket  = t.key[7:0] ^ 8'h3C;
        return r;
    endfunction

    function automatic ht_result_t bogus();
        ht_result_t r;
        r.cmd = OP_SEARCH; r.rescode = TABLE_FULL; r.key = 16'hDEAD;
        r.value = 16'hBEEF; r.bucket = 8'hEE;
        return r;
    endfunction

    function automatic ht_result_t exp_result(input vec_t v, input ht_pdata_t t);
        ht_result_t r;
        if (v.legal) begin
            r = engine_model(t);
        end else begin
            r = '0;
            r.cmd = v.cmd;
            r.rescode = UNKNOWN_CMD;
        end
        return r;
    endfunction

    task automatic clear_eng();
        eng_task_ready_i   = '0;
        eng_result_valid_i = '0;
        eng_result_i       = '0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ctrl"}, 64'({task_ready_o, busy_o, result_valid_o, wd_err_o}), 64'(4'b1000));
        chk({tag, "_eng_valid"}, 64'(eng_task_valid_o), 64'(0));
        chk({tag, "_eng_rready"}, 64'(eng_result_ready_o), 64'(0));
        chk({tag, "_task_reg"}, 64'(eng_task_o), 64'(0));
        chk({tag, "_result_reg"}, 64'(result_o), 64'(0));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        ht_pdata_t  t, junk;
        ht_result_t first, exp_r;
        int         vcount = 0, rcount = 0, rvcount = 0;
        bit         done = 0;
        first = '0;
        t.cmd = v.cmd; t.key = v.key; t.value = v.value;
        junk.cmd = OP_INSERT; junk.key = ~v.key; junk.value = ~v.value;
        chk($sformatf("v%0d_idle_ready", idx), 64'(task_ready_o), 64'(1));
        task_i = t;
        task_valid_i = 1'b1;
        sb_q.push_back(exp_result(v, t));
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            step();
            // task input keeps offering a different task while one is in flight
            if (cyc == 1) task_i = junk;
            clear_eng();
            result_ready_i = 1'b0;
            for (int e = 0; e < int'(ENG_NUM); e++) eng_result_i[e] = bogus();
            chk($sformatf("v%0d_c%0d_inflight", idx, cyc),
                64'({task_ready_o, busy_o, wd_err_o}), 64'(3'b010));
            chk($sformatf("v%0d_c%0d_valid_sel", idx, cyc), 64'(eng_task_valid_o & ~v.onehot), 64'(0));
            chk($sformatf("v%0d_c%0d_rready_sel", idx, cyc), 64'(eng_result_ready_o & ~v.onehot), 64'(0));
            if (v.noise) begin
                eng_result_valid_i = (eng_task_valid_o != 0) ? 4'hF : ~v.onehot;
            end
            if (eng_task_valid_o != 0) begin
                chk($sformatf("v%0d_c%0d_eng_task", idx, cyc), 64'(eng_task_o), 64'(t));
                if (vcount == v.rdy - 1) eng_task_ready_i = v.onehot;
                vcount++;
            end
            if (eng_result_ready_o != 0) begin
                if (rcount == v.res) begin
                    eng_result_valid_i[v.eng] = 1'b1;
                    eng_result_i[v.eng] = engine_model(t);
                end
                rcount++;
            end
            if (result_valid_o) begin
                if (rvcount == 0) begin
                    chk($sformatf("v%0d_latency", idx), 64'(cyc), 64'(v.exp_lat));
                    first = result_o;
                end else begin
                    chk($sformatf("v%0d_c%0d_result_stable", idx, cyc), 64'(result_o), 64'(first));
                end
                if (rvcount == v.rr) begin
                    result_ready_i = 1'b1;
                    task_valid_i = 1'b0;
                    if (sb_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL v%0d_scoreboard: result %0h with nothing expected", idx, result_o);
                    end else begin
                        exp_r = sb_q.pop_front();
                        chk($sformatf("v%0d_scoreboard", idx), 64'(result_o), 64'(exp_r));
                    end
                    done = 1;
                end
                rvcount++;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL v%0d_timeout: no result handshake, expected one within 60 cycles", idx);
            task_valid_i = 1'b0;
        end
        chk($sformatf("v%0d_valid_cycles", idx), 64'(vcount), 64'(v.exp_vcyc));
        chk($sformatf("v%0d_wait_cycles", idx), 64'(rcount), 64'(v.legal ? v.res + 1 : 0));
        step();
        result_ready_i = 1'b0;
        clear_eng();
        chk($sformatf("v%0d_back_idle", idx), 64'({task_ready_o, busy_o, result_valid_o}), 64'(3'b100));
    endtask

    initial begin
        ht_pdata_t wt;
        rst_i = 1'b1;
        task_i = '0;
        task_valid_i = 1'b0;
        result_ready_i = 1'b0;
        clear_eng();

        vecs[0] = mk(OP_INIT,   16'h0003, 16'h1111, 1, 3, 1, 0, 0,  0, 1, 3);
        vecs[1] = mk(OP_INSERT, 16'h1234, 16'hABCD, 1, 1, 5, 0, 0,  0, 5, 7);
        vecs[2] = mk(OP_DELETE, 16'h00F0, 16'h0000, 1, 2, 2, 3, 0,  1, 2, 7);
        vecs[3] = mk(OP_SEARCH, 16'h4321, 16'h0F0F, 1, 0, 1, 1, 10, 0, 1, 4);
        vecs[4] = mk(ht_cmd_t'(3'd6), 16'h7777, 16'h8888, 0, 0, 1, 0, 0, 0, 0, 1);
        vecs[5] = mk(ht_cmd_t'(3'd4), 16'h0101, 16'h0202, 0, 0, 1, 0, 3, 1, 0, 1);
        vecs[6] = mk(OP_SEARCH, 16'hC0DE, 16'h5555, 1, 0, 3, 2, 2,  1, 3, 7);

        step();
        step();
        check_reset_state("reset");
        rst_i = 1'b0;
        step();

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Engine never ready: watchdog flags, task stays dispatched, reset recovers
        wt.cmd = OP_INSERT; wt.key = 16'h2222; wt.value = 16'h3333;
        task_i = wt;
        task_valid_i = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            step();
            task_valid_i = 1'b0;
            if (cyc == 16) chk("wd_before_limit", 64'(wd_err_o), 64'(0));
            if (cyc == 17) chk("wd_at_limit", 64'(wd_err_o), 64'(1));
        end
        chk("wd_sticky", 64'(wd_err_o), 64'(1));
        chk("wd_still_dispatching", 64'({busy_o, eng_task_valid_o}), 64'(5'b10010));
        rst_i = 1'b1;
        step();
        check_reset_state("wd_reset");
        rst_i = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            step();
            chk($sformatf("post_reset_quiet_%0d", cyc),
                64'({result_valid_o, wd_err_o, task_ready_o}), 64'(3'b001));
        end

        run_vec(vecs[0], 7);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
